if_fetch_queue: RTL
===================

# if_fetch_queue

Parametrised instruction-fetch stage for the LEGv8 pipeline. It replaces the single-register PC/PCSrc fetch with a PC generator feeding a DEPTH-entry fetch queue. The queue carries {pc, pc_incr, inst} to decode over a valid/ready handshake. It sits between the combinational instruction memory (`inst_mem`) and the ID stage, and adds hold, redirect-flush and back-pressure support.

## Interface
- `WORD`, 64, datapath / PC width in bits
- `INST_SIZE`, 32, instruction width in bits
- `DEPTH`, 4, fetch-queue entries; power of two, 2..16
- `RESET_PC`, 0, PC value loaded on reset
- `clk`  input  1  clock; all state updates on rising edge
- `rst`  input  1  asynchronous, active-high reset
- `ALU_res`  input  WORD  branch target from the EX add ALU
- `ALUOut`  input  WORD  register-jump target from the EX main ALU
- `PCSrc`  input  2  00 = sequential; 01 = redirect to `ALU_res`; 10/11 = redirect to `ALUOut`
- `hold`  input  1  freeze fetch; PC held and no push
- `imem_pc`  output  WORD  fetch address to `inst_mem` (equals the PC register)
- `imem_inst`  input  INST_SIZE  instruction returned combinationally for `imem_pc`
- `dec_valid`  output  1  queue head valid
- `dec_ready`  input  1  decode accepts the head this cycle
- `dec_pc`  output  WORD  PC of the head instruction
- `dec_pc_incr`  output  WORD  `dec_pc` + 4 of the head
- `dec_inst`  output  INST_SIZE  head instruction
- `q_count`  output  $clog2(DEPTH)+1  number of occupied entries
- `redirect_cnt`  output  16  number of redirects taken since reset; saturates at 16'hFFFF

## Operation
- Reset values:
  - PC = `RESET_PC`; read and write pointers = 0; `q_count` = 0; `redirect_cnt` = 0.
  - `dec_valid` = 0.
  - `dec_pc`, `dec_pc_incr` and `dec_inst` read the entry-0 storage, which is cleared to 0 on reset.
- Pop: `pop` = `dec_valid` & `dec_ready`. The read pointer advances modulo DEPTH.
- Space: `space` = (`q_count` < DEPTH) | `pop`. A full queue accepts a push in the same cycle as a pop.
- Redirect: `redirect` = (`PCSrc` != 00).
  - Target = `ALU_res` (01) or `ALUOut` (1x), with bits [1:0] forced to 0.
  - On the edge: PC <= target; both pointers <= 0; `q_count` <= 0; `redirect_cnt` += 1 (saturating).
  - No push occurs in a redirect cycle. A `pop` in the same cycle is still a completed handshake; the head is consumed by decode.
- Push: `push` = !`redirect` & !`hold` & `space`.
  - Writes {`imem_pc`, `imem_pc` + 4, `imem_inst`} at the write pointer.
  - Write pointer advances modulo DEPTH.
  - PC <= PC + 4.
- Stall: when !`redirect` & (`hold` | !`space`), PC holds and there is no push.
- `q_count` next value = `q_count` + `push` − `pop` (zeroed on redirect).
- Priority: `rst` > `redirect` > `hold` > full.
- Arithmetic: PC + 4 is computed modulo 2^WORD. A PC of 2^WORD − 4 wraps to 0.

## Timing
- Fetch-to-decode latency is 1 cycle. An instruction pushed at edge N is visible on `dec_*` after edge N when the queue was empty.
- Sequential throughput is 1 instruction per cycle while `dec_ready` stays high.
- Redirect penalty:
  - `PCSrc` is sampled at edge N.
  - `imem_pc` = target after edge N.
  - The target instruction appears on `dec_*` after edge N+1.
  - `dec_valid` = 0 between edges N and N+1.
- `dec_*` and `q_count` are registered state. They have no combinational path from `dec_ready`, `PCSrc` or `hold`.
- `imem_pc` is registered. `imem_inst` is consumed in the same cycle.
- Asserting `rst` mid-operation clears the queue immediately (asynchronously). Fetch restarts from `RESET_PC` on the first edge after `rst` deasserts.

## Test plan
Memory image for all scenarios: the word at address 4k holds the value k (DEPTH = 4).

- Reset release, `dec_ready` = 1, `PCSrc` = 00 -> `dec_inst` sequence 0,1,2,3,… one per cycle; `dec_pc_incr` = `dec_pc` + 4.
- Backpressure: `dec_ready` = 0 for 6 cycles -> `q_count` saturates at 4; `imem_pc` holds at 16; on release, `dec_inst` = 0,1,2,3,4 with no loss and no duplication.
- `PCSrc` = 01 with `ALU_res` = 124 -> queue flushed; `dec_valid` is 0 for one cycle; next `dec_inst` = 31, then 32; `redirect_cnt` = 1.
- `PCSrc` = 10 and then `PCSrc` = 11, each with `ALUOut` = 60 -> each redirect yields `dec_inst` = 15; `ALUOut` = 62 also yields 15 (alignment).
- `hold` = 1 for 3 cycles with `dec_ready` = 1 -> queue drains to `q_count` = 0; PC frozen; the next instruction after release is the successor with no gap in sequence.
- Redirect while full with simultaneous pop; then `rst` asserted mid-run -> popped head consumed, `q_count` = 0; all outputs return to their reset values; the first instruction after release is 0.

Source files
------------

// File: rtl/if_fetch_queue.sv
// Instruction-fetch stage: PC generator feeding a DEPTH-entry queue of {pc, pc_incr, inst}
// toward decode over valid/ready, with hold, redirect-flush and back-pressure.
module if_fetch_queue #(
  parameter int              WORD      = 64,
  parameter int              INST_SIZE = 32,
  parameter int              DEPTH     = 4,
  parameter logic [WORD-1:0] RESET_PC  = '0
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [WORD-1:0]            ALU_res,
  input  logic [WORD-1:0]            ALUOut,
  input  logic [1:0]                 PCSrc,
  input  logic                       hold,
  output logic [WORD-1:0]            imem_pc,
  input  logic [INST_SIZE-1:0]       imem_inst,
  output logic                       dec_valid,
  input  logic                       dec_ready,
  output logic [WORD-1:0]            dec_pc,
  output logic [WORD-1:0]            dec_pc_incr,
  output logic [INST_SIZE-1:0]       dec_inst,
  output logic [$clog2(DEPTH):0]     q_count,
  output logic [15:0]                redirect_cnt
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [WORD-1:0] FOUR = WORD'(4);

  logic [WORD-1:0]      pc, pc_next, pc_plus4, target;
  logic [AW-1:0]        rd_ptr, rd_next, wr_ptr, wr_next;
  logic [CW-1:0]        cnt_next;
  logic [15:0]          rcnt_next;
  logic                 redirect, pop, push, space;

  logic [WORD-1:0]      q_pc   [DEPTH];
  logic [WORD-1:0]      q_incr [DEPTH];
  logic [INST_SIZE-1:0] q_inst [DEPTH];

  assign imem_pc     = pc;
  assign pc_plus4    = pc + FOUR;
  assign dec_valid   = (q_count != '0);
  assign dec_pc      = q_pc[rd_ptr];
  assign dec_pc_incr = q_incr[rd_ptr];
  assign dec_inst    = q_inst[rd_ptr];

  assign redirect = (PCSrc != 2'b00);
  assign pop      = dec_valid & dec_ready;
  assign space    = (q_count < CW'(DEPTH)) | pop;
  assign push     = !redirect & !hold & space;

  // Redirect targets are word aligned regardless of the low ALU bits.
  always_comb begin
    target = PCSrc[1] ? ALUOut : ALU_res;
    target[1:0] = 2'b00;
  end

  always_comb begin
    pc_next   = pc;
    rd_next   = rd_ptr;
    wr_next   = wr_ptr;
    cnt_next  = q_count;
    rcnt_next = redirect_cnt;
    if (redirect) begin
      pc_next  = target;
      rd_next  = '0;
      wr_next  = '0;
      cnt_next = '0;
      if (redirect_cnt != 16'hFFFF)
        rcnt_next = redirect_cnt + 16'd1;
    end else begin
      if (pop)
        rd_next = rd_ptr + AW'(1);
      if (push) begin
        wr_next = wr_ptr + AW'(1);
        pc_next = pc_plus4;
      end
      cnt_next = q_count + CW'(push) - CW'(pop);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pc           <= RESET_PC;
      rd_ptr       <= '0;
      wr_ptr       <= '0;
      q_count      <= '0;
      redirect_cnt <= '0;
    end else begin
      pc           <= pc_next;
      rd_ptr       <= rd_next;
      wr_ptr       <= wr_next;
      q_count      <= cnt_next;
      redirect_cnt <= rcnt_next;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        q_pc[i]   <= '0;
        q_incr[i] <= '0;
        q_inst[i] <= '0;
      end
    end else if (push) begin
      q_pc[wr_ptr]   <= pc;
      q_incr[wr_ptr] <= pc_plus4;
      q_inst[wr_ptr] <= imem_inst;
    end
  end

endmodule
